// File: rtl/svc_rv_wb_arb_pkg.sv
// Shared types for the write-back port arbiter (svc_rv_wb_arb).
// Optional statistics build: SVC_RV_WB_ARB_STATS_EN.
package svc_rv_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_t;

    localparam int         WB_XLEN = 32;
    localparam logic [4:0] REG_X0  = 5'd0;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/svc_rv_wb_arb_fifo.sv
// Deferred-result FIFO with per-entry rd kill and a parallel hazard-match vector.
// With SVC_RV_WB_ARB_STATS_EN the per-entry kill vector is exported for counting.
module svc_rv_wb_arb_fifo
    import svc_rv_wb_arb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [4:0]       push_rd,
    input  logic [XLEN-1:0]  push_data,
    input  logic             pop,
    input  logic             kill_en,
    input  logic [4:0]       kill_rd,
    input  logic [4:0]       pend_rd,
    output logic             empty,
    output logic             full,
    output logic             one_left,
    output logic             head_valid,
    output logic [4:0]       head_rd,
    output logic [XLEN-1:0]  head_data,
    output logic [DEPTH-1:0] pend_vec
`ifdef SVC_RV_WB_ARB_STATS_EN
    ,
    output logic [DEPTH-1:0] kill_vec
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr, rd_ptr, occ;
    logic [AW-1:0]     wr_idx, rd_idx;
    logic [DEPTH-1:0]  valid, kill_hit;
    logic [4:0]        rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];

    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign occ        = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign one_left   = (occ == {{AW{1'b0}}, 1'b1});
    assign head_valid = !empty && valid[rd_idx];
    assign head_rd    = rd_mem[rd_idx];
    assign head_data  = data_mem[rd_idx];

    // Valid bits are cleared on pop, so a set bit always marks a live, occupied slot.
    always_comb begin
        kill_hit = '0;
        pend_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_hit[i] = kill_en && valid[i] && (rd_mem[i] == kill_rd);
            pend_vec[i] = valid[i] && (rd_mem[i] == pend_rd);
        end
    end

`ifdef SVC_RV_WB_ARB_STATS_EN
    assign kill_vec = kill_hit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_hit[i]) valid[i] <= 1'b0;
            end
            if (pop) begin
                valid[rd_idx] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            // On a full push+pop the slot being refilled is the one being popped; push wins.
            if (push) begin
                valid[wr_idx] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_idx]   <= push_rd;
            data_mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/svc_rv_wb_arb.sv
// Register-file write-port arbiter: pipeline WB wins, long-latency results defer/drain.
// Define SVC_RV_WB_ARB_STATS_EN to add saturating stall/kill/defer counters.
module svc_rv_wb_arb
    import svc_rv_wb_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lat_valid,
    output logic            lat_ready,
    input  logic [4:0]      lat_rd,
    input  logic [XLEN-1:0] lat_data,
    output logic            stall_req,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [4:0]      pend_rd,
    output logic            pend_hit
`ifdef SVC_RV_WB_ARB_STATS_EN
    ,
    output logic [31:0]     stat_stall_cnt,
    output logic [31:0]     stat_kill_cnt,
    output logic [31:0]     stat_defer_cnt
`endif
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);

    wb_arb_state_t    state, state_next;
    logic [SW-1:0]    starve_cnt, starve_next;

    logic             empty, full, one_left, head_valid;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_data;
    logic [DEPTH-1:0] pend_vec;

    logic pipe_wr, head_pop, head_wr, blocked, drains;
    logic lat_acc, lat_zero, bypass, lat_waw, push;

    // A pipeline write presented during a forced stall is discarded.
    assign pipe_wr  = pipe_valid && (pipe_rd != REG_X0) && !stall_req;
    assign head_pop = !empty && (!head_valid || !pipe_wr);
    assign head_wr  = head_pop && head_valid;
    assign blocked  = head_valid && pipe_wr;

    assign lat_ready = !rst && (!full || head_pop);
    assign lat_acc   = lat_valid && lat_ready;
    assign lat_zero  = (lat_rd == REG_X0);
    assign bypass    = lat_acc && !lat_zero && empty && !pipe_wr;
    assign lat_waw   = lat_acc && !lat_zero && pipe_wr && (pipe_rd == lat_rd);
    assign push      = lat_acc && !lat_zero && !bypass && !lat_waw;
    assign drains    = !push && (empty || (one_left && head_pop));

    assign pend_hit = (pend_rd != REG_X0) && ((|pend_vec) || (lat_acc && (lat_rd == pend_rd)));

`ifdef SVC_RV_WB_ARB_STATS_EN
    logic [DEPTH-1:0] kill_vec;
`endif

    svc_rv_wb_arb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_rd    (lat_rd),
        .push_data  (lat_data),
        .pop        (head_pop),
        .kill_en    (pipe_wr),
        .kill_rd    (pipe_rd),
        .pend_rd    (pend_rd),
        .empty      (empty),
        .full       (full),
        .one_left   (one_left),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .pend_vec   (pend_vec)
`ifdef SVC_RV_WB_ARB_STATS_EN
        ,
        .kill_vec   (kill_vec)
`endif
    );

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            IDLE: begin
                starve_next = '0;
                if (push) state_next = WAIT;
            end
            WAIT: begin
                if (head_pop)     starve_next = '0;
                else if (blocked) starve_next = starve_cnt + 1'b1;
                if (blocked && (starve_cnt == STARVE_TOP)) begin
                    state_next  = FORCE;
                    starve_next = '0;
                end else if (drains) begin
                    state_next = IDLE;
                end
            end
            FORCE: begin
                starve_next = '0;
                state_next  = drains ? IDLE : WAIT;
            end
            default: begin
                state_next  = IDLE;
                starve_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= REG_X0;
            rf_wdata   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            stall_req  <= (state_next == FORCE);
            rf_we      <= pipe_wr || head_wr || bypass;
            if (pipe_wr) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (head_wr) begin
                rf_waddr <= head_rd;
                rf_wdata <= head_data;
            end else if (bypass) begin
                rf_waddr <= lat_rd;
                rf_wdata <= lat_data;
            end
        end
    end

`ifdef SVC_RV_WB_ARB_STATS_EN
    logic [31:0] kill_inc;

    // Killed FIFO entries plus accepted results dropped (x0 target or same-cycle WAW).
    always_comb begin
        kill_inc = 32'(lat_waw || (lat_acc && lat_zero));
        for (int i = 0; i < DEPTH; i++) begin
            kill_inc = kill_inc + 32'(kill_vec[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_kill_cnt  <= '0;
            stat_defer_cnt <= '0;
        end else begin
            stat_stall_cnt <= sat_add32(stat_stall_cnt, 32'(state == FORCE));
            stat_kill_cnt  <= sat_add32(stat_kill_cnt, kill_inc);
            stat_defer_cnt <= sat_add32(stat_defer_cnt, 32'(push));
        end
    end
`endif

    no_pipe_during_stall: assert property (@(posedge clk) disable iff (rst) stall_req |-> !pipe_valid)
        else $error("pipe_valid asserted while stall_req is high");

endmodule
